// File: rtl/ws2812_shift_register.sv
// ws2812_shift_register: rotating parallel-load / serial-out register holding one WS2812B
// frame segment (WIDTH bits). Define SHREG_FRAME_DONE_EN to add the registered frameDone pulse.
module ws2812_shift_register #(
    parameter int WIDTH = 96,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadRegister,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             genDone,
`ifdef SHREG_FRAME_DONE_EN
    output logic             frameDone,
`endif
    output logic             registerBit
);

    logic [WIDTH-1:0] sr_r;

    // Data register: reset beats load beats advance; advancing rotates so no bit is ever lost.
    always_ff @(posedge clk) begin
        if (reset == 1'b0) begin
            sr_r <= '0;
        end else if (loadRegister == 1'b1) begin
            sr_r <= loadValue;
        end else if (genDone == 1'b1) begin
            sr_r <= {sr_r[WIDTH-2:0], sr_r[WIDTH-1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign registerBit = sr_r[WIDTH-1];

`ifdef SHREG_FRAME_DONE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             frame_done_r;

    // Advance counter and one-cycle pulse after the advance that wraps cnt back to zero.
    always_ff @(posedge clk) begin
        if (reset == 1'b0) begin
            cnt_r        <= '0;
            frame_done_r <= 1'b0;
        end else if (loadRegister == 1'b1) begin
            cnt_r        <= '0;
            frame_done_r <= 1'b0;
        end else if (genDone == 1'b1) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r        <= '0;
                frame_done_r <= 1'b1;
            end else begin
                cnt_r        <= cnt_r + CNT_W'(1);
                frame_done_r <= 1'b0;
            end
        end else begin
            cnt_r        <= cnt_r;
            frame_done_r <= 1'b0;
        end
    end

    assign frameDone = frame_done_r;
`endif

endmodule

// File: tb/tb_ws2812_shift_register.sv
// Self-checking bench for ws2812_shift_register: vector table, directed corner sequences and
// random traffic against a position-index reference model.
module tb_ws2812_shift_register;

    localparam int W = 96;

    logic         clk;
    logic         reset;
    logic         loadRegister;
    logic [W-1:0] loadValue;
    logic         genDone;
    logic         registerBit;
`ifdef SHREG_FRAME_DONE_EN
    logic         frameDone;
`endif

    ws2812_shift_register #(.WIDTH(W), .CNT_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .loadRegister (loadRegister),
        .loadValue    (loadValue),
        .genDone      (genDone),
`ifdef SHREG_FRAME_DONE_EN
        .frameDone    (frameDone),
`endif
        .registerBit  (registerBit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the loaded word plus the number of advances since the load.
    // The bit on the wire is the loaded word read from the MSB downwards, modulo W.
    logic [W-1:0] m_val;
    int           m_k;
    logic         m_fd;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         gd;
        logic [W-1:0] val;
        logic         exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic g, input logic [W-1:0] v);
        reset        = r;
        loadRegister = l;
        genDone      = g;
        loadValue    = v;
        m_fd = r && !l && g && (m_k == W - 1);
        if (!r) begin
            m_val = '0;
            m_k   = 0;
        end else if (l) begin
            m_val = v;
            m_k   = 0;
        end else if (g) begin
            m_k = (m_k + 1) % W;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        chk(name, registerBit, m_val[W - 1 - m_k]);
`ifdef SHREG_FRAME_DONE_EN
        chk({name, "_framedone"}, frameDone, m_fd);
`endif
    endtask

    logic [W-1:0] ab;
    logic [W-1:0] ends1;
    logic [W-1:0] ones;
    logic [W-1:0] rv;
    logic         held;

    initial begin
        ab    = 96'hAAAAAA_BBBBBB_AAAAAA_BBBBBB;
        ends1 = {1'b1, 94'd0, 1'b1};
        ones  = '1;
        reset = 1'b0; loadRegister = 1'b0; genDone = 1'b0; loadValue = '0;
        m_val = '0; m_k = 0; m_fd = 1'b0;

        // rst ld gd value exp
        tbl[0]  = '{1'b0, 1'b1, 1'b0, ones,  1'b0};  // reset beats load
        tbl[1]  = '{1'b0, 1'b1, 1'b1, ones,  1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, ab,    1'b1};  // load beats advance
        tbl[3]  = '{1'b1, 1'b1, 1'b1, ab,    1'b1};  // held load re-captures
        tbl[4]  = '{1'b1, 1'b0, 1'b1, ab,    1'b0};  // bit 94
        tbl[5]  = '{1'b1, 1'b0, 1'b1, ab,    1'b1};  // bit 93
        tbl[6]  = '{1'b1, 1'b0, 1'b1, ab,    1'b0};  // bit 92
        tbl[7]  = '{1'b1, 1'b0, 1'b0, ab,    1'b0};  // hold
        tbl[8]  = '{1'b1, 1'b0, 1'b1, ab,    1'b1};  // bit 91
        tbl[9]  = '{1'b1, 1'b1, 1'b1, ends1, 1'b1};  // collision: load, no rotate
        tbl[10] = '{1'b1, 1'b0, 1'b1, ends1, 1'b0};  // rotate once -> 0..03

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].ld, tbl[i].gd, tbl[i].val);
            chk($sformatf("table_%0d", i), registerBit, tbl[i].exp);
            check_model($sformatf("table_model_%0d", i));
        end

        // Rotate not shift: 94 more advances reach 95 total, where the LSB 1 surfaces.
        for (int i = 0; i < 94; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("rot_stream");
        end
        chk("rot_after_95", registerBit, 1'b1);
        step(1'b1, 1'b0, 1'b1, '0);
        chk("rot_after_96", registerBit, 1'b1);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("rot_second_frame");
        end

        // Full wrap of the A/B pattern, then keep rotating for 1000 ns.
        step(1'b1, 1'b1, 1'b0, ab);
        chk("ab_load", registerBit, 1'b1);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("ab_wrap");
        end
        chk("ab_wrap_msb", registerBit, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("ab_run");
        end

        // Stall: genDone low for 10 cycles leaves the register untouched.
        held = registerBit;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, ones);
            chk("stall_hold", registerBit, held);
            check_model("stall_model");
        end

        // Frame sequences: full frame, then a reload at advance 50.
        step(1'b1, 1'b1, 1'b0, ab);
        for (int i = 0; i < W + 2; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("frame_full");
        end
        step(1'b1, 1'b1, 1'b0, ends1);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("frame_pre_reload");
        end
        rv = {$urandom, $urandom, $urandom};
        step(1'b1, 1'b1, 1'b1, rv);
        check_model("frame_reload");
        for (int i = 0; i < W + 2; i++) begin
            step(1'b1, 1'b0, 1'b1, '0);
            check_model("frame_after_reload");
        end

        // Reset in mid-rotation discards data.
        step(1'b0, 1'b0, 1'b1, '0);
        chk("mid_reset", registerBit, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rv = {$urandom, $urandom, $urandom};
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), rv);
            check_model("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
